// File: rtl/upsample_replicate.sv
// Nearest-neighbour upscaler: each pixel repeats Factor times per line, and each line
// is replayed Factor times from an internal line buffer.
module upsample_replicate #(
  parameter int WidthIn   = 1,
  parameter int Factor    = 2,
  parameter int LineWidth = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WidthIn-1:0] data_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WidthIn-1:0] data_o,
  output logic               last_o
);

  localparam int RepW = (Factor > 1) ? $clog2(Factor) : 1;
  localparam int ColW = $clog2(LineWidth);
  localparam logic [RepW-1:0] RepMax = RepW'(Factor - 1);
  localparam logic [ColW-1:0] ColMax = ColW'(LineWidth - 1);
  localparam bit SingleRep = (Factor == 1);

  typedef enum logic {FILL, REPLAY} state_t;

  state_t            state, state_nx;
  logic [RepW-1:0]   rep_h, rep_h_nx;
  logic [RepW-1:0]   rep_v, rep_v_nx;
  logic [ColW-1:0]   col, col_nx, col_inc, wr_col;
  logic [WidthIn-1:0] data_nx;
  logic              valid_nx, last_nx;
  logic              rep_last, col_last, accept, beat;

  logic [WidthIn-1:0] mem [LineWidth];

  assign rep_last = (rep_h == RepMax);
  assign col_last = (col == ColMax);
  assign col_inc  = col_last ? '0 : col + 1'b1;
  assign ready_o  = (state == FILL) &
                    (!valid_o | (ready_i & rep_last & (!col_last | SingleRep)));
  assign accept   = valid_i & ready_o;
  assign beat     = valid_o & ready_i;

  // A pixel accepted while the previous one drains belongs to the next column.
  assign wr_col = valid_o ? col_inc : col;

  always_ff @(posedge clk_i) begin
    if (!rst_i && accept) begin
      mem[wr_col] <= data_i;
    end
  end

  always_comb begin
    state_nx = state;
    rep_h_nx = rep_h;
    rep_v_nx = rep_v;
    col_nx   = col;
    data_nx  = data_o;
    valid_nx = valid_o;
    if (state == FILL) begin
      if (beat) begin
        if (!rep_last) begin
          rep_h_nx = rep_h + 1'b1;
        end else if (!col_last || SingleRep) begin
          rep_h_nx = '0;
          col_nx   = col_inc;
          valid_nx = accept;
          if (accept) begin
            data_nx = data_i;
          end
        end else begin
          rep_h_nx = '0;
          col_nx   = '0;
          rep_v_nx = RepW'(1);
          state_nx = REPLAY;
          data_nx  = mem[0];
        end
      end else if (accept) begin
        valid_nx = 1'b1;
        data_nx  = data_i;
      end
    end else begin
      if (beat) begin
        if (!rep_last) begin
          rep_h_nx = rep_h + 1'b1;
        end else if (!col_last) begin
          rep_h_nx = '0;
          col_nx   = col_inc;
          data_nx  = mem[col_inc];
        end else if (rep_v != RepMax) begin
          rep_h_nx = '0;
          rep_v_nx = rep_v + 1'b1;
          col_nx   = '0;
          data_nx  = mem[0];
        end else begin
          rep_h_nx = '0;
          rep_v_nx = '0;
          col_nx   = '0;
          valid_nx = 1'b0;
          state_nx = FILL;
        end
      end
    end
    last_nx = valid_nx & (col_nx == ColMax) & (rep_h_nx == RepMax);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= FILL;
      rep_h   <= '0;
      rep_v   <= '0;
      col     <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else begin
      state   <= state_nx;
      rep_h   <= rep_h_nx;
      rep_v   <= rep_v_nx;
      col     <= col_nx;
      data_o  <= data_nx;
      valid_o <= valid_nx;
      last_o  <= last_nx;
    end
  end

endmodule
